// File: rtl/expslot_multi_if.sv
// Cartridge-side bus bundle for the expanded-slot controller: strobes, address/data,
// per-slot selects and the decoded subslot outputs.
interface expslot_multi_if #(
  parameter int unsigned NUM_SLOTS = 2
);
  logic                   enable;
  logic [15:0]            addr;
  logic [7:0]             cdin;
  logic [7:0]             cdout;
  logic                   busreq;
  logic [NUM_SLOTS-1:0]   sltsl_n;
  logic                   rd_n;
  logic                   wr_n;
  logic [4*NUM_SLOTS-1:0] slotsel;
  logic [8*NUM_SLOTS-1:0] subreg;

  modport master (
    output enable, addr, cdin, sltsl_n, rd_n, wr_n,
    input  cdout, busreq, slotsel, subreg
  );

  modport slave (
    input  enable, addr, cdin, sltsl_n, rd_n, wr_n,
    output cdout, busreq, slotsel, subreg
  );
endinterface

// File: rtl/expslot_multi.sv
// MSX expanded-slot controller for up to four primary slots: secondary-slot registers at
// FFFFh with timed readback, and page-to-subslot one-hot decode per slot.
module expslot_multi #(
  parameter int unsigned NUM_SLOTS     = 2,
  parameter logic [3:0]  EXPANDED_MASK = 4'b1111,
  parameter int unsigned HOLD_CYCLES   = 2,
  parameter bit          INVERT_READ   = 1'b1
) (
  input logic            clk,
  input logic            reset_n,
  expslot_multi_if.slave bus
);

  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned KW   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {StIdle, StWrHold, StRdDrive, StRdWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [KW-1:0]   slot_q, slot_d;
  logic [7:0]      subreg_q [NUM_SLOTS];
  logic [7:0]      subreg_d [NUM_SLOTS];
  logic [7:0]      cdout_q, cdout_d;
  logic            busreq_q, busreq_d;

  logic          act_found;
  logic [KW-1:0] act_slot;
  logic          is_ffff;
  logic          qual;
  logic          wr_release;
  logic          rd_release;

  // Lowest-numbered selected slot wins.
  always_comb begin
    act_found = 1'b0;
    act_slot  = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!bus.sltsl_n[i]) begin
        act_found = 1'b1;
        act_slot  = KW'(i);
      end
    end
  end

  assign is_ffff    = (bus.addr == 16'hFFFF);
  assign qual       = bus.enable && is_ffff && act_found && EXPANDED_MASK[act_slot];
  assign wr_release = bus.enable && ((bus.wr_n && bus.rd_n) || bus.sltsl_n[slot_q]);
  assign rd_release = bus.enable && (bus.rd_n || bus.sltsl_n[slot_q]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    cdout_d  = cdout_q;
    busreq_d = busreq_q;
    subreg_d = subreg_q;
    unique case (state_q)
      StIdle: begin
        if (qual) begin
          slot_d = act_slot;
          if (!bus.wr_n) begin
            subreg_d[act_slot] = bus.cdin;
            state_d            = StWrHold;
          end else if (!bus.rd_n) begin
            cdout_d  = INVERT_READ ? ~subreg_q[act_slot] : subreg_q[act_slot];
            busreq_d = 1'b1;
            cnt_d    = CntW'(HOLD_CYCLES - 1);
            state_d  = StRdDrive;
          end
        end
      end
      StWrHold: begin
        if (wr_release) state_d = StIdle;
      end
      StRdDrive: begin
        // Hold time runs on clk alone; once expired, a released strobe ends the read at once.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rd_release) begin
          busreq_d = 1'b0;
          state_d  = StIdle;
        end else begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (rd_release) begin
          busreq_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      slot_q   <= '0;
      cdout_q  <= '0;
      busreq_q <= 1'b0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) subreg_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      cdout_q  <= cdout_d;
      busreq_q <= busreq_d;
      subreg_q <= subreg_d;
    end
  end

  always_comb begin
    logic [1:0] sub;
    logic [3:0] onehot;
    bus.slotsel = '0;
    bus.subreg  = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      bus.subreg[8*i +: 8] = subreg_q[i];
      unique case (bus.addr[15:14])
        2'd0:    sub = subreg_q[i][1:0];
        2'd1:    sub = subreg_q[i][3:2];
        2'd2:    sub = subreg_q[i][5:4];
        default: sub = subreg_q[i][7:6];
      endcase
      onehot = 4'b0001 << sub;
      if (act_found && (act_slot == KW'(i))) begin
        if (!EXPANDED_MASK[i]) begin
          bus.slotsel[4*i] = 1'b1;
        end else if (!is_ffff) begin
          bus.slotsel[4*i +: 4] = onehot;
        end
      end
    end
  end

  assign bus.cdout  = cdout_q;
  assign bus.busreq = busreq_q;

endmodule
